std_mem_d1_stream_writer: RTL and testbench

Initiator for the one-dimensional memory port protocol: addr0, write_data, write_en in, done back. A go/done-controlled engine accepts words from a valid/ready input stream. It writes them to consecutive addresses 0..N-1 of an attached std_mem_d1 instance, issuing one write and waiting for the memory's done before the next. It sits between a streaming producer (DMA/testbench/host loader) and a Calyx memory, in place of a compiler-generated write loop.

---
 rtl/std_mem_d1_stream_writer.sv | 171 +++++++++++++++++
 tb/tb_std_mem_d1_stream_writer.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/std_mem_d1_stream_writer.sv
// Stream-to-memory writer for a one-dimensional Calyx-style memory port.
// A go/done engine takes words from a valid/ready stream and writes them to
// addresses 0..eff_len-1. It issues one write at a time and waits for the
// memory's done before fetching the next word.
module std_mem_d1_stream_writer #(
    parameter int WIDTH    = 32,
    parameter int SIZE     = 16,
    parameter int IDX_SIZE = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                go,
    input  logic [IDX_SIZE:0]   len,
    output logic                done,
    output logic [IDX_SIZE:0]   count,
    input  logic [WIDTH-1:0]    in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [IDX_SIZE-1:0] addr0,
    output logic [WIDTH-1:0]    write_data,
    output logic                write_en,
    input  logic                mem_done
);

    // SIZE expressed in the width of len/count so comparisons stay unsigned and sized.
    localparam logic [IDX_SIZE:0] LP_SIZE = SIZE[IDX_SIZE:0];
    localparam logic [IDX_SIZE:0] LP_ONE  = {{IDX_SIZE{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WRITE = 3'd2,
        S_ACK   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Saturate the requested length to the memory depth so addr0 can never
    // run past the last word.
    function automatic logic [IDX_SIZE:0] clamp_len(input logic [IDX_SIZE:0] req);
        logic [IDX_SIZE:0] res;
        res = (req > LP_SIZE) ? LP_SIZE : req;
        return res;
    endfunction

    state_t              r_state;
    state_t              w_next;

    logic [IDX_SIZE:0]   r_eff_len;
    logic [IDX_SIZE:0]   r_count;
    logic                r_armed;
    logic [IDX_SIZE-1:0] r_addr;
    logic [WIDTH-1:0]    r_wdata;

    logic                w_start;
    logic [IDX_SIZE:0]   w_len_clamped;
    logic                w_fetch_hs;
    logic                w_ack;
    logic [IDX_SIZE:0]   w_count_inc;
    logic                w_last;

    // Start needs the engine idle and armed; armed blocks a held-high go
    // from launching back-to-back operations.
    assign w_start       = (r_state == S_IDLE) && go && r_armed;
    assign w_len_clamped = clamp_len(len);
    assign w_fetch_hs    = (r_state == S_FETCH) && in_valid;
    assign w_ack         = (r_state == S_ACK) && mem_done;
    assign w_count_inc   = r_count + LP_ONE;
    assign w_last        = (w_count_inc == r_eff_len);

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next = (w_len_clamped == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (in_valid) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                w_next = S_ACK;
            end
            S_ACK: begin
                if (mem_done) begin
                    w_next = w_last ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Strobes are pure decodes of the state register so reset clears them
    // in the same instant it asserts.
    always_comb begin
        done     = 1'b0;
        in_ready = 1'b0;
        write_en = 1'b0;
        case (r_state)
            S_FETCH: in_ready = 1'b1;
            S_WRITE: write_en = 1'b1;
            S_DONE:  done     = 1'b1;
            default: begin
                done     = 1'b0;
                in_ready = 1'b0;
                write_en = 1'b0;
            end
        endcase
    end

    // Operation length and acknowledged-word counter; count holds after done
    // until the next start clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_eff_len <= '0;
            r_count   <= '0;
        end else if (w_start) begin
            r_eff_len <= w_len_clamped;
            r_count   <= '0;
        end else if (w_ack) begin
            r_count   <= w_count_inc;
        end
    end

    // Address and data are captured at the stream handshake so they stay
    // stable across WRITE and ACK; the address is taken before count advances,
    // so it never reaches SIZE and never wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_fetch_hs) begin
            r_addr  <= r_count[IDX_SIZE-1:0];
            r_wdata <= in_data;
        end
    end

    // Re-arm whenever go is seen low; disarm on completion so a go that
    // stays high does not restart the engine.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_armed <= 1'b1;
        end else if (!go) begin
            r_armed <= 1'b1;
        end else if (r_state == S_DONE) begin
            r_armed <= 1'b0;
        end
    end

    assign count      = r_count;
    assign addr0      = r_addr;
    assign write_data = r_wdata;

endmodule

// File: tb/tb_std_mem_d1_stream_writer.sv
// Testbench for std_mem_d1_stream_writer: a stream driver, a std_mem_d1-like
// memory model with configurable done latency, and a scoreboard monitor that
// checks every write and every done against hand-computed expectations.
module tb_std_mem_d1_stream_writer;

    localparam int WIDTH    = 32;
    localparam int SIZE     = 16;
    localparam int IDX_SIZE = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic                go;
    logic [IDX_SIZE:0]   len;
    logic                done;
    logic [IDX_SIZE:0]   count;
    logic [WIDTH-1:0]    in_data;
    logic                in_valid;
    logic                in_ready;
    logic [IDX_SIZE-1:0] addr0;
    logic [WIDTH-1:0]    write_data;
    logic                write_en;
    logic                mem_done;

    std_mem_d1_stream_writer #(
        .WIDTH    (WIDTH),
        .SIZE     (SIZE),
        .IDX_SIZE (IDX_SIZE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .go         (go),
        .len        (len),
        .done       (done),
        .count      (count),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .addr0      (addr0),
        .write_data (write_data),
        .write_en   (write_en),
        .mem_done   (mem_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Memory model: stores on write_en and returns done mem_delay cycles later.
    logic [WIDTH-1:0] mem [0:SIZE-1];
    int   mem_delay = 1;
    int   wait_cnt;
    logic pend;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_done <= 1'b0;
            pend     <= 1'b0;
            wait_cnt <= 0;
        end else begin
            mem_done <= 1'b0;
            if (write_en) begin
                mem[addr0] <= write_data;
                if (mem_delay <= 1) begin
                    mem_done <= 1'b1;
                end else begin
                    pend     <= 1'b1;
                    wait_cnt <= mem_delay - 1;
                end
            end else if (pend) begin
                if (wait_cnt == 1) begin
                    mem_done <= 1'b1;
                    pend     <= 1'b0;
                end else begin
                    wait_cnt <= wait_cnt - 1;
                end
            end
        end
    end

    // Scoreboard queues.
    typedef struct {
        int                  cyc;
        logic [IDX_SIZE-1:0] addr;
        logic [WIDTH-1:0]    data;
    } wr_t;
    typedef struct {
        int                cyc;
        logic [IDX_SIZE:0] cnt;
    } dn_t;

    wr_t wq[$];
    dn_t dq[$];
    int  go_cyc = 0;

    // Stream source: words and the number of in_ready-high cycles to hold
    // in_valid low before presenting each word.
    logic [WIDTH-1:0] sq[$];
    int               stq[$];

    initial begin : stream_drv
        int   n;
        int   st;
        int   guard;
        logic hs;
        in_valid = 1'b0;
        in_data  = '0;
        @(posedge clk); #1;
        forever begin
            if (sq.size() == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end else begin
                st       = stq.pop_front();
                in_valid = 1'b0;
                n        = 0;
                guard    = 0;
                while (n < st && guard < 200) begin
                    @(negedge clk);
                    if (in_ready) n++;
                    guard++;
                end
                if (st > 0) begin
                    @(posedge clk); #1;
                end
                in_data  = sq.pop_front();
                in_valid = 1'b1;
                hs       = 1'b0;
                guard    = 0;
                while (!hs && guard < 500) begin
                    @(negedge clk);
                    hs = in_ready;
                    @(posedge clk); #1;
                    guard++;
                end
                in_valid = 1'b0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT writes or signals done.
    int   n_we      = 0;
    int   n_done    = 0;
    int   n_rdy     = 0;
    int   n_ackviol = 0;
    logic ack_pend  = 1'b0;

    initial begin : monitor
        wr_t w;
        dn_t d;
        forever begin
            @(negedge clk);
            if (reset) begin
                ack_pend = 1'b0;
            end else begin
                if (in_ready) n_rdy++;
                if (write_en) begin
                    n_we++;
                    if (ack_pend) n_ackviol++;
                    ack_pend = 1'b1;
                    if (wq.size() == 0) begin
                        chk("unexpected_write", 1, 0);
                    end else begin
                        w = wq.pop_front();
                        chk("wr_addr", longint'(addr0), longint'(w.addr));
                        chk("wr_data", longint'(write_data), longint'(w.data));
                        chk("wr_cycle", longint'(cyc - go_cyc), longint'(w.cyc));
                    end
                end
                if (mem_done) ack_pend = 1'b0;
                if (done) begin
                    n_done++;
                    if (dq.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        d = dq.pop_front();
                        chk("done_count", longint'(count), longint'(d.cnt));
                        chk("done_cycle", longint'(cyc - go_cyc), longint'(d.cyc));
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic push_word(input logic [WIDTH-1:0] dw, input int st);
        sq.push_back(dw);
        stq.push_back(st);
    endtask

    task automatic exp_wr(input int c, input int a, input logic [WIDTH-1:0] dw);
        wr_t w;
        w.cyc  = c;
        w.addr = a[IDX_SIZE-1:0];
        w.data = dw;
        wq.push_back(w);
    endtask

    task automatic exp_done(input int c, input int cnt);
        dn_t d;
        d.cyc = c;
        d.cnt = cnt[IDX_SIZE:0];
        dq.push_back(d);
    endtask

    task automatic start(input int l);
        len    = l[IDX_SIZE:0];
        go     = 1'b1;
        go_cyc = cyc;
    endtask

    task automatic wait_done(input int bound, input string nm);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk(nm, longint'(seen), 1);
        step();
    endtask

    initial begin : main
        int snap_we;
        int snap_dn;
        int snap_rdy;
        reset = 1'b0;
        go    = 1'b0;
        len   = '0;
        #1 reset = 1'b1;
        #1;
        chk("rst_done", longint'(done), 0);
        chk("rst_in_ready", longint'(in_ready), 0);
        chk("rst_write_en", longint'(write_en), 0);
        chk("rst_count", longint'(count), 0);
        chk("rst_addr0", longint'(addr0), 0);
        chk("rst_write_data", longint'(write_data), 0);
        step(); step();
        reset = 1'b0;
        step();

        // Nominal len=3, zero-wait stream, 1-cycle memory.
        push_word(32'hA, 0); push_word(32'hB, 0); push_word(32'hC, 0);
        exp_wr(2, 0, 32'hA); exp_wr(5, 1, 32'hB); exp_wr(8, 2, 32'hC);
        exp_done(10, 3);
        step();
        start(3);
        step();
        go  = 1'b0;
        len = 5'd7;
        wait_done(40, "t1_done_seen");
        chk("t1_mem0", longint'(mem[0]), 32'hA);
        chk("t1_mem1", longint'(mem[1]), 32'hB);
        chk("t1_mem2", longint'(mem[2]), 32'hC);
        step();

        // Zero length.
        snap_we  = n_we;
        snap_rdy = n_rdy;
        exp_done(1, 0);
        start(0);
        step();
        go = 1'b0;
        wait_done(10, "t2_done_seen");
        chk("t2_no_write_en", longint'(n_we - snap_we), 0);
        chk("t2_no_in_ready", longint'(n_rdy - snap_rdy), 0);
        chk("t2_count", longint'(count), 0);
        step();

        // Stream stall of 5 cycles before the second word.
        push_word(32'h1111_0001, 0); push_word(32'h2222_0002, 5); push_word(32'h3333_0003, 0);
        exp_wr(2, 0, 32'h1111_0001); exp_wr(10, 1, 32'h2222_0002); exp_wr(13, 2, 32'h3333_0003);
        exp_done(15, 3);
        step();
        start(3);
        step();
        go = 1'b0;
        wait_done(60, "t3_done_seen");
        chk("t3_mem1", longint'(mem[1]), 32'h2222_0002);
        step();

        // Length clamp (19 -> 16) with a 3-cycle memory.
        mem_delay = 3;
        snap_dn   = n_done;
        for (int i = 0; i < SIZE; i++) begin
            push_word(32'h100 + i, 0);
            exp_wr(2 + 5 * i, i, 32'h100 + i);
        end
        exp_done(81, 16);
        step();
        start(19);
        step();
        go = 1'b0;
        wait_done(200, "t4_done_seen");
        repeat (5) step();
        chk("t4_single_done", longint'(n_done - snap_dn), 1);
        chk("t4_mem15", longint'(mem[15]), 32'h10F);
        chk("t4_no_write_in_ack", longint'(n_ackviol), 0);
        mem_delay = 1;
        step();

        // Reset during ACK of word 2 with go held high.
        for (int i = 0; i < 5; i++) push_word(32'h51 + i, 0);
        exp_wr(2, 0, 32'h51); exp_wr(5, 1, 32'h52);
        exp_wr(2, 0, 32'h53); exp_wr(5, 1, 32'h54); exp_wr(8, 2, 32'h55);
        exp_done(10, 3);
        step();
        start(3);
        repeat (6) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t5_write_en", longint'(write_en), 0);
        chk("t5_in_ready", longint'(in_ready), 0);
        chk("t5_done", longint'(done), 0);
        chk("t5_count", longint'(count), 0);
        step(); step();
        reset  = 1'b0;
        go_cyc = cyc;
        wait_done(40, "t5_done_seen");
        chk("t5_mem0", longint'(mem[0]), 32'h53);
        go = 1'b0;
        step(); step();

        // Go held high after done must not restart; a low cycle re-arms.
        push_word(32'h61, 0); push_word(32'h62, 0);
        exp_wr(2, 0, 32'h61); exp_wr(5, 1, 32'h62);
        exp_done(7, 2);
        step();
        start(2);
        wait_done(40, "t6_done_seen");
        snap_we = n_we;
        snap_dn = n_done;
        repeat (10) step();
        chk("t6_no_restart_we", longint'(n_we - snap_we), 0);
        chk("t6_no_restart_done", longint'(n_done - snap_dn), 0);
        chk("t6_count_held", longint'(count), 2);
        go = 1'b0;
        push_word(32'h63, 0);
        exp_wr(2, 0, 32'h63);
        exp_done(4, 1);
        step();
        start(1);
        step();
        @(negedge clk);
        chk("t6_count_cleared", longint'(count), 0);
        step();
        wait_done(20, "t6b_done_seen");
        go = 1'b0;
        repeat (4) step();

        chk("wq_empty", longint'(wq.size()), 0);
        chk("dq_empty", longint'(dq.size()), 0);
        chk("ack_viol_total", longint'(n_ackviol), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit so the bench always ends.
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
